// File: rtl/muxn_rr_if.sv
// Handshake bundle for muxn_rr: N producer channels in, one registered consumer channel out.
// Latency: none (wires only).
// Backpressure: carried by in_ready (mux -> producers) and out_ready (consumer -> mux).
// Ports: in_data/in_valid/in_ready per channel, in_last when MUXN_RR_LOCK_EN is defined,
//        out_data/out_ch/out_valid/out_ready on the merged side.
// Modports: slave = the mux, master = the surrounding producers and consumer.
interface muxn_rr_if #(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int SW = $clog2(N);

    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
`ifdef MUXN_RR_LOCK_EN
    logic [N-1:0]   in_last;
`endif
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_ch;
    logic           out_valid;
    logic           out_ready;

    modport slave (
`ifdef MUXN_RR_LOCK_EN
        input  in_last,
`endif
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );

    modport master (
`ifdef MUXN_RR_LOCK_EN
        output in_last,
`endif
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/muxn_rr.sv
// N-channel valid/ready merger with manual-select and round-robin modes, one output register.
// Latency: 1 cycle from accept to out_valid; 1 beat/cycle sustained with out_ready high.
// Backpressure: in_ready is combinational from out_ready; a stalled full output register gates all inputs.
// Ports: clk, rst_n (async, active-low), mode (0 manual / 1 round-robin), sel (manual channel),
//        bus (muxn_rr_if.slave) carrying the per-channel inputs and the registered output.
// Option: MUXN_RR_LOCK_EN adds in_last and holds a round-robin grant for a whole packet.
module muxn_rr #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [$clog2(N)-1:0] sel,
    muxn_rr_if.slave             bus
);
    localparam int SW = $clog2(N);

    logic [SW-1:0] ptr;
    logic          load;
    logic          rr_vld;
    logic [SW-1:0] rr_ch;
    logic          grant_vld;
    logic [SW-1:0] grant_ch;
    logic          accept;
    logic [SW-1:0] next_ptr;
    int            idx;

`ifdef MUXN_RR_LOCK_EN
    logic          locked;
    logic [SW-1:0] lock_ch;
`endif

    // The output register can take a beat when empty or being drained this cycle.
    assign load = !bus.out_valid || bus.out_ready;

    // Round-robin search: first valid channel at or after ptr, wrapping at N.
    always_comb begin
        rr_vld = 1'b0;
        rr_ch  = '0;
        idx    = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!rr_vld && bus.in_valid[idx]) begin
                rr_vld = 1'b1;
                rr_ch  = SW'(idx);
            end
        end
    end

    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        if (!mode) begin
            // Out-of-range select grants nothing.
            if (32'(sel) < N) begin
                grant_vld = 1'b1;
                grant_ch  = sel;
            end
        end else begin
`ifdef MUXN_RR_LOCK_EN
            // Mid-packet the grant stays put even if the owner has gone idle.
            if (locked) begin
                grant_vld = 1'b1;
                grant_ch  = lock_ch;
            end else begin
                grant_vld = rr_vld;
                grant_ch  = rr_ch;
            end
`else
            grant_vld = rr_vld;
            grant_ch  = rr_ch;
`endif
        end
    end

    always_comb begin
        bus.in_ready = '0;
        if (grant_vld) begin
            bus.in_ready[grant_ch] = load;
        end
    end

    assign accept   = grant_vld && load && bus.in_valid[grant_ch];
    assign next_ptr = (grant_ch == SW'(N - 1)) ? '0 : grant_ch + SW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_ch    <= '0;
            ptr           <= '0;
        end else begin
            if (accept) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= bus.in_data[int'(grant_ch) * W +: W];
                bus.out_ch    <= grant_ch;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end

            // Pointer only moves in round-robin mode; manual mode leaves it frozen.
            if (mode && accept) begin
`ifdef MUXN_RR_LOCK_EN
                if (bus.in_last[grant_ch]) begin
                    ptr <= next_ptr;
                end
`else
                ptr <= next_ptr;
`endif
            end
        end
    end

`ifdef MUXN_RR_LOCK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked  <= 1'b0;
            lock_ch <= '0;
        end else if (!mode) begin
            locked  <= 1'b0;
        end else if (accept) begin
            locked  <= !bus.in_last[grant_ch];
            lock_ch <= grant_ch;
        end
    end
`endif

endmodule
